// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin owner of a 4:1 data mux that feeds one shared
// valid/ready resource port. Grants are registered, so the mux select stays
// stable for a whole transfer. A granted requester may hold the grant for a
// locked burst of up to BURST_MAX beats.
module mux_sel_arbiter #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic [3:0]        lock,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic              res_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        sel,
    output logic [3:0]        gnt,
    output logic [3:0]        ack
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0] gnt_q, gnt_d;
    logic [3:0] beat_cnt_q, beat_cnt_d;

    logic [1:0] winner;
    logic [1:0] scan_idx;
    logic       scan_found;
    logic       owner_req;
    logic       beat_valid;
    logic       beat_accept;
    logic       burst_room;

    // Round-robin pick: first set req bit at or above rr_ptr, wrapping 3->0.
    always_comb begin
        winner     = rr_ptr_q;
        scan_idx   = '0;
        scan_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = rr_ptr_q + 2'(k);
            if (!scan_found && req[scan_idx]) begin
                winner     = scan_idx;
                scan_found = 1'b1;
            end
        end
    end

    // Beat qualification for the current owner.
    always_comb begin
        owner_req   = req[sel_q];
        beat_valid  = (state_q == StGrant) && owner_req;
        beat_accept = beat_valid && res_ready;
        // Room for another beat after the one being accepted now.
        burst_room  = ({1'b0, beat_cnt_q} + 5'd1) < 5'(BURST_MAX);
    end

    // Next-state logic for the grant FSM, pointer and burst counter.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        beat_cnt_d = beat_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (req != 4'b0000) begin
                    sel_d      = winner;
                    gnt_d      = 4'b0001 << winner;
                    beat_cnt_d = '0;
                    state_d    = StGrant;
                end
            end
            StGrant: begin
                if (!owner_req) begin
                    // Owner withdrew before acceptance: release without a beat.
                    rr_ptr_d = sel_q + 2'd1;
                    gnt_d    = '0;
                    state_d  = StIdle;
                end else if (beat_accept) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                    if (!(lock[sel_q] && burst_room)) begin
                        rr_ptr_d = sel_q + 2'd1;
                        gnt_d    = '0;
                        state_d  = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    // All arbiter state; reset aborts any transfer immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            sel_q      <= '0;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Data path is a pure mux on the registered select; no data register.
    always_comb begin
        out_data = in0;
        unique case (sel_q)
            2'd0: out_data = in0;
            2'd1: out_data = in1;
            2'd2: out_data = in2;
            2'd3: out_data = in3;
            default: out_data = in0;
        endcase
    end

    // Handshake outputs; ack only ever targets the registered owner.
    always_comb begin
        out_valid = beat_valid;
        ack       = beat_accept ? (4'b0001 << sel_q) : 4'b0000;
        sel       = sel_q;
        gnt       = gnt_q;
    end

endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
- Round-robin arbiter that shares one 8-bit destination port among four requesters.
- Owns the 2-bit select of the 4:1 8-bit datapath mux (In0..In3 -> Out) and the valid/ready handshake to the shared resource, e.g. the writeback or memory port.
- Drives the mux through a registered grant, so select is glitch-free and stable for the whole transfer.
- Supports locked multi-beat bursts.

Parameters:
- DATA_W, 8, width of each requester data bus and of out_data.
- BURST_MAX, 4, maximum beats per locked grant before forced re-arbitration (1..15).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- req  input  4  request per requester; bit i = requester i.
- lock  input  4  requester i asks to keep the grant after the current beat.
- in0  input  DATA_W  requester 0 data.
- in1  input  DATA_W  requester 1 data.
- in2  input  DATA_W  requester 2 data.
- in3  input  DATA_W  requester 3 data.
- res_ready  input  1  shared resource accepts a beat this cycle.
- out_valid  output  1  a beat is presented to the resource.
- out_data  output  DATA_W  muxed data of the granted requester.
- sel  output  2  registered mux select (granted index).
- gnt  output  4  one-hot grant, registered.
- ack  output  4  one-cycle pulse to requester i when its beat is accepted.

Behaviour:
- Reset (asynchronous, immediate on rst=1):
  - state=IDLE, sel=0, gnt=0, out_valid=0, ack=0.
  - rr_ptr=0 (highest priority = requester 0), beat_cnt=0.
  - out_data=in0 (follows sel).
- out_data is purely combinational from sel: 0->in0, 1->in1, 2->in2, 3->in3. There is no register on the data path.
- States: IDLE, GRANT.
- IDLE:
  - If req==0: stay in IDLE.
  - Otherwise pick the first set req bit scanning from rr_ptr upward, modulo 4.
  - Register sel=winner, gnt=onehot(winner), beat_cnt=0, go to GRANT.
  - Latency is one cycle from req to out_valid.
- GRANT:
  - out_valid=1 while req[sel]=1.
  - Beat accepted when out_valid & res_ready. That cycle: ack[sel]=1 and beat_cnt increments.
  - After an accepted beat, if lock[sel]=1, req[sel]=1 and beat_cnt+1 < BURST_MAX: stay in GRANT, keep sel, and present the next beat on the next cycle.
  - Otherwise: rr_ptr=sel+1 (mod 4, wraps 3->0), gnt=0, return to IDLE.
  - There is one idle bubble between grants.
- res_ready low: out_valid held, sel and data source held. There is no timeout.
- Requester drops req[sel] while in GRANT without acceptance: out_valid=0 that cycle, no ack, grant released, rr_ptr=sel+1, go to IDLE.
- ack is only ever asserted for the granted index. ack is never asserted outside GRANT and never coincides with a grant change.
- Requests from non-granted requesters are ignored until IDLE; no request is queued or lost internally, since requesters hold req until ack.
- Simultaneous requests are resolved by round-robin only; no fixed-priority starvation.
- A burst that reaches BURST_MAX beats is forcibly ended even with lock=1. The same requester can win again only after others are scanned.
- lock is sampled only on the accepted-beat cycle.
- rst asserted mid-transfer aborts immediately: no ack and out_valid=0. After release, arbitration restarts from requester 0.

Test Plan:
- Reset then req=4'b0001, in0=8'hA5, res_ready=1:
  - Expect sel=0, out_valid=1, out_data=A5 one cycle after req.
  - Expect ack=4'b0001 that cycle, then IDLE.
- req=4'b1111 held, res_ready=1, lock=0:
  - Expect grant order 0,1,2,3,0, each grant followed by one bubble cycle.
  - Expect exactly one ack per grant.
- Grant 2 with res_ready=0 for 3 cycles while in2 changes 11->22->33, then res_ready=1:
  - Expect out_valid=1, sel=2 stable throughout, and out_data tracking in2.
  - Expect ack[2] only on the ready cycle.
- lock[1]=1, req=4'b0011, BURST_MAX=4, res_ready=1:
  - Expect 4 consecutive beats with ack[1], then release.
  - Expect next grant to requester 0 (wrap-around of rr_ptr).
- req[3] dropped mid-GRANT with res_ready=0:
  - Expect out_valid=0, no ack, return to IDLE.
  - Expect next pointer at requester 0.
- rst pulsed asynchronously (between edges) during a locked burst:
  - Expect all outputs at reset values immediately.
  - Expect the first post-reset grant to be the lowest set req index from 0.
